// File: rtl/sccb_init_pkg.sv
// Shared entry format, opcodes and FSM encoding for the OV2640 SCCB init sequencer.
// SCCB_INIT_VERIFY_EN adds the readback states to the encoding.
package sccb_init_pkg;
  localparam int ENTRY_W  = 18;
  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

`ifdef SCCB_INIT_VERIFY_EN
  // Bank-select register reads back differently, so it is never verified.
  localparam logic [7:0] BANK_SEL = 8'hFF;
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_WR_REQ, ST_WR_REL,
`ifdef SCCB_INIT_VERIFY_EN
    ST_RD_REQ, ST_RD_REL, ST_CMP,
`endif
    ST_DELAY, ST_DONE, ST_FAIL
  } state_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [1:0] op,
                                                  input logic [7:0] addr,
                                                  input logic [7:0] data);
    return {op, addr, data};
  endfunction
endpackage

// File: rtl/sccb_init_rom.sv
// Combinational OV2640 init table; every index not listed decodes as END.
module sccb_init_rom
  import sccb_init_pkg::*;
#(
  parameter int ROM_DEPTH = 64
) (
  input  logic [$clog2(ROM_DEPTH)-1:0] i_addr,
  output logic [ENTRY_W-1:0]           o_entry
);
  logic [31:0] w_a;
  assign w_a = 32'(i_addr);

  always_comb begin
    case (w_a)
      32'd0:   o_entry = mk_entry(OP_WRITE, 8'hFF, 8'h01);  // sensor bank
      32'd1:   o_entry = mk_entry(OP_WRITE, 8'h12, 8'h80);  // soft reset
      32'd2:   o_entry = mk_entry(OP_DELAY, 8'h00, 8'h0A);
      32'd3:   o_entry = mk_entry(OP_WRITE, 8'hFF, 8'h00);  // DSP bank
      32'd4:   o_entry = mk_entry(OP_WRITE, 8'h2C, 8'hFF);
      32'd5:   o_entry = mk_entry(OP_DELAY, 8'h00, 8'h00);
      32'd6:   o_entry = mk_entry(OP_WRITE, 8'h3C, 8'h32);
      default: o_entry = mk_entry(OP_END,   8'h00, 8'h00);
    endcase
  end
endmodule

// File: rtl/sccb_init_seq.sv
// Table-driven OV2640 register init sequencer driving a CoreSCCB master.
// Define SCCB_INIT_VERIFY_EN to read back and compare every non-bank-select write.
module sccb_init_seq
  import sccb_init_pkg::*;
#(
  parameter logic [7:0] DEV_ID     = 8'h60,
  parameter int         ROM_DEPTH  = 64,
  parameter int         DELAY_UNIT = 24000,
  parameter int         TIMEOUT    = 2400000
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         go,
  output logic                         busy,
  output logic                         init_done,
  output logic                         error,
  output logic [$clog2(ROM_DEPTH)-1:0] err_index,
  output logic                         sccb_start,
  output logic                         sccb_rw,
  output logic [7:0]                   sccb_ip_addr,
  output logic [7:0]                   sccb_sub_addr,
  output logic [7:0]                   sccb_data_in,
  input  logic [7:0]                   sccb_data_out,
  input  logic                         sccb_done
);
  localparam int IDX_W = $clog2(ROM_DEPTH);
  localparam int CNT_W = $clog2(255 * DELAY_UNIT);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx, r_eidx;
  logic               r_busy, r_init, r_err, r_start, r_rw, r_dly_ld;
  logic [7:0]         r_ip, r_sub, r_din;
  logic [CNT_W-1:0]   r_dcnt;
  logic [TMO_W-1:0]   r_tmo;
  logic [ENTRY_W-1:0] w_entry;
  logic [1:0]         w_op;
  logic [7:0]         w_addr, w_data;
  logic               w_last, w_tmo_hit;
  logic [CNT_W-1:0]   w_dly_n;

  sccb_init_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (.i_addr(r_idx), .o_entry(w_entry));

  assign w_op      = w_entry[OP_MSB:OP_LSB];
  assign w_addr    = w_entry[ADDR_MSB:ADDR_LSB];
  assign w_data    = w_entry[DATA_MSB:DATA_LSB];
  assign w_last    = (r_idx == LAST_IDX);
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_dly_n   = CNT_W'(w_data) * CNT_W'(DELAY_UNIT) - CNT_W'(1);

`ifdef SCCB_INIT_VERIFY_EN
  logic [7:0] r_rdata;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^sccb_data_out;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_eidx   <= '0;
      r_busy   <= 1'b0;
      r_init   <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_rw     <= 1'b0;
      r_ip     <= 8'h00;
      r_sub    <= 8'h00;
      r_din    <= 8'h00;
      r_dcnt   <= '0;
      r_tmo    <= '0;
      r_dly_ld <= 1'b0;
`ifdef SCCB_INIT_VERIFY_EN
      r_rdata  <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: if (go) begin
          r_idx   <= '0;
          r_init  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_tmo    <= '0;
          r_dly_ld <= 1'b1;
          case (w_op)
            OP_WRITE: begin
              r_ip    <= DEV_ID;
              r_rw    <= 1'b0;
              r_sub   <= w_addr;
              r_din   <= w_data;
              r_start <= 1'b1;
              r_state <= ST_WR_REQ;
            end
            OP_DELAY: r_state <= ST_DELAY;
            OP_END: begin
              r_init  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
            default: begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_eidx  <= r_idx;
              r_state <= ST_FAIL;
            end
          endcase
        end
        // r_start gate: a done left high from before counts only once start has been seen.
        ST_WR_REQ: if (sccb_done && r_start) begin
          r_start <= 1'b0;
          r_state <= ST_WR_REL;
        end else if (w_tmo_hit) begin
          r_start <= 1'b0;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_eidx  <= r_idx;
          r_state <= ST_FAIL;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
        ST_WR_REL: if (!sccb_done) begin
`ifdef SCCB_INIT_VERIFY_EN
          if (w_addr != BANK_SEL) begin
            r_ip    <= DEV_ID | 8'h01;
            r_rw    <= 1'b1;
            r_start <= 1'b1;
            r_tmo   <= '0;
            r_state <= ST_RD_REQ;
          end else begin
            r_state <= w_last ? ST_DONE : ST_FETCH;
            r_idx   <= w_last ? r_idx : r_idx + IDX_W'(1);
            r_init  <= w_last;
            r_busy  <= !w_last;
          end
`else
          r_state <= w_last ? ST_DONE : ST_FETCH;
          r_idx   <= w_last ? r_idx : r_idx + IDX_W'(1);
          r_init  <= w_last;
          r_busy  <= !w_last;
`endif
        end
`ifdef SCCB_INIT_VERIFY_EN
        ST_RD_REQ: if (sccb_done && r_start) begin
          r_start <= 1'b0;
          r_rdata <= sccb_data_out;
          r_state <= ST_RD_REL;
        end else if (w_tmo_hit) begin
          r_start <= 1'b0;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_eidx  <= r_idx;
          r_state <= ST_FAIL;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
        ST_RD_REL: if (!sccb_done) r_state <= ST_CMP;
        ST_CMP: if (r_rdata != w_data) begin
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_eidx  <= r_idx;
          r_state <= ST_FAIL;
        end else begin
          r_state <= w_last ? ST_DONE : ST_FETCH;
          r_idx   <= w_last ? r_idx : r_idx + IDX_W'(1);
          r_init  <= w_last;
          r_busy  <= !w_last;
        end
`endif
        // First DELAY cycle loads the counter, so d ticks cost d*DELAY_UNIT+2 overall.
        ST_DELAY: if (r_dly_ld && w_data != 8'h00) begin
          r_dly_ld <= 1'b0;
          r_dcnt   <= w_dly_n;
        end else if (r_dly_ld || r_dcnt == '0) begin
          r_dly_ld <= 1'b0;
          r_state  <= w_last ? ST_DONE : ST_FETCH;
          r_idx    <= w_last ? r_idx : r_idx + IDX_W'(1);
          r_init   <= w_last;
          r_busy   <= !w_last;
        end else begin
          r_dcnt <= r_dcnt - CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign init_done     = r_init;
  assign error         = r_err;
  assign err_index     = r_eidx;
  assign sccb_start    = r_start;
  assign sccb_rw       = r_rw;
  assign sccb_ip_addr  = r_ip;
  assign sccb_sub_addr = r_sub;
  assign sccb_data_in  = r_din;
endmodule

// File: tb/tb_sccb_init_seq.sv
// Scoreboard bench: a table-walking model predicts transactions, latencies and final status.
`timescale 1ns/1ps
module tb_sccb_init_seq;
  localparam int         DEPTH = 8;
  localparam int         DU    = 10;
  localparam int         TMO   = 100;
  localparam logic [7:0] DEV   = 8'h60;

  logic       PCLK = 1'b0;
  logic       PRESET, go;
  logic       busy, init_done, error;
  logic [2:0] err_index;
  logic       sccb_start, sccb_rw;
  logic [7:0] sccb_ip_addr, sccb_sub_addr, sccb_data_in, sccb_data_out;
  logic       sccb_done;

  always #5 PCLK = ~PCLK;

  sccb_init_seq #(.DEV_ID(DEV), .ROM_DEPTH(DEPTH), .DELAY_UNIT(DU), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .go(go), .busy(busy), .init_done(init_done),
    .error(error), .err_index(err_index), .sccb_start(sccb_start), .sccb_rw(sccb_rw),
    .sccb_ip_addr(sccb_ip_addr), .sccb_sub_addr(sccb_sub_addr),
    .sccb_data_in(sccb_data_in), .sccb_data_out(sccb_data_out), .sccb_done(sccb_done));

  typedef struct {
    bit fin; bit tmo; logic [7:0] ip; bit rw; logic [7:0] sub; logic [7:0] dat;
    int gap; bit err; int eidx;
  } item_t;

  item_t      q[$];
  int         nchk = 0, nerr = 0;
  bit         mode_tmo = 0, mode_bad = 0;
  logic [17:0] tbl [DEPTH];
  logic [7:0] mem [256];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    nchk++; nerr++;
    $display("FAIL %s got=event want=none t=%0t", nm, $time);
  endtask

  function automatic item_t mk(bit fin, bit tmo, logic [7:0] ip, bit rw, logic [7:0] sub,
                               logic [7:0] dat, int gap, bit err, int eidx);
    item_t it;
    it.fin = fin; it.tmo = tmo; it.ip = ip; it.rw = rw; it.sub = sub; it.dat = dat;
    it.gap = gap; it.err = err; it.eidx = eidx;
    return it;
  endfunction

  // gap: cycles from the trigger sample (go accepted / done seen low) to the next event sample, +1.
  function automatic void plan(bit tmo, bit badrd);
    int gap;
    logic [1:0] op;
    logic [7:0] a, d;
    gap = 2;
    for (int i = 0; i < DEPTH; i++) begin
      op = tbl[i][17:16]; a = tbl[i][15:8]; d = tbl[i][7:0];
      if (op == 2'b00) begin
        q.push_back(mk(0, tmo, DEV, 0, a, d, gap, 0, 0));
        if (tmo) begin q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, i)); return; end
        gap = 2;
`ifdef SCCB_INIT_VERIFY_EN
        if (a != 8'hFF) begin
          q.push_back(mk(0, 0, DEV | 8'h01, 1, a, d, 1, 0, 0));
          if (badrd && d != 8'h00) begin q.push_back(mk(1, 0, 0, 0, 0, 0, 2, 1, i)); return; end
          gap = 3;
        end
`endif
        if (i == DEPTH - 1) begin q.push_back(mk(1, 0, 0, 0, 0, 0, gap - 1, 0, 0)); return; end
      end else if (op == 2'b01) begin
        gap += int'(d) * DU + 2;
        if (i == DEPTH - 1) begin q.push_back(mk(1, 0, 0, 0, 0, 0, gap - 1, 0, 0)); return; end
      end else if (op == 2'b10) begin
        q.push_back(mk(1, 0, 0, 0, 0, 0, gap, 0, 0)); return;
      end else begin
        q.push_back(mk(1, 0, 0, 0, 0, 0, gap, 1, i)); return;
      end
    end
  endfunction

  // CoreSCCB stand-in: random completion latency, four-phase release.
  initial begin
    int st, cnt, rel;
    st = 0; cnt = 0; rel = 0;
    sccb_done = 1'b0; sccb_data_out = 8'h00;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin st = 0; sccb_done = 1'b0; end
      else case (st)
        0: if (sccb_start && !mode_tmo) begin cnt = $urandom_range(1, 60); st = 1; end
        1: begin
          cnt--;
          if (cnt == 0) begin
            if (sccb_rw) sccb_data_out = mode_bad ? 8'h00 : mem[sccb_sub_addr];
            else mem[sccb_sub_addr] = sccb_data_in;
            sccb_done = 1'b1; st = 2;
          end
        end
        2: if (!sccb_start) begin rel = $urandom_range(0, 3); st = 3; end
        default: if (rel == 0) begin sccb_done = 1'b0; st = 0; end else rel--;
      endcase
    end
  end

  // Monitor: samples 1 ns after each rising edge and checks against the queued predictions.
  initial begin
    item_t cur, it;
    int cyc, trig, rise;
    logic p_start, p_done, p_busy;
    cyc = 0; trig = 0; rise = 0; p_start = 0; p_done = 0; p_busy = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    forever begin
      @(posedge PCLK); #1; cyc++;
      if (PRESET) begin
        p_start = 0; p_done = 0; p_busy = 0;
      end else begin
        if (go && !p_busy) begin
          trig = cyc;
          chk("go_busy", int'(busy), 1);
          chk("go_clear", int'({init_done, error}), 0);
        end
        if (!sccb_done && p_done) trig = cyc;
        if (sccb_start && !p_start) begin
          rise = cyc;
          if (q.size() == 0 || q[0].fin) begin
            bad("unexpected_start");
            if (q.size() != 0) void'(q.pop_front());
          end else begin
            cur = q.pop_front();
            chk("ip_addr", int'(sccb_ip_addr), int'(cur.ip));
            chk("rw", int'(sccb_rw), int'(cur.rw));
            chk("sub_addr", int'(sccb_sub_addr), int'(cur.sub));
            chk("data_in", int'(sccb_data_in), int'(cur.dat));
            chk("start_cycle", cyc, trig + cur.gap - 1);
          end
        end
        if (sccb_done && !p_done) begin
          chk("start_drop", int'(sccb_start), 0);
          chk("sub_hold", int'(sccb_sub_addr), int'(cur.sub));
          chk("data_hold", int'(sccb_data_in), int'(cur.dat));
        end
        if (!sccb_start && p_start) begin
          chk("timeout_kind", int'(!sccb_done), int'(cur.tmo));
          if (!sccb_done) chk("timeout_len", cyc - rise, TMO);
        end
        if (!busy && p_busy) begin
          if (q.size() == 0 || !q[0].fin) bad("unexpected_end");
          else begin
            it = q.pop_front();
            chk("init_done", int'(init_done), int'(!it.err));
            chk("error", int'(error), int'(it.err));
            if (it.err) chk("err_index", int'(err_index), it.eidx);
            if (it.gap != 0) chk("end_cycle", cyc, trig + it.gap - 1);
          end
        end
        p_start = sccb_start; p_done = sccb_done; p_busy = busy;
      end
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_init_done"}, int'(init_done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_err_index"}, int'(err_index), 0);
    chk({tag, "_start"}, int'(sccb_start), 0);
    chk({tag, "_rw"}, int'(sccb_rw), 0);
    chk({tag, "_ip"}, int'(sccb_ip_addr), 0);
    chk({tag, "_sub"}, int'(sccb_sub_addr), 0);
    chk({tag, "_data"}, int'(sccb_data_in), 0);
  endtask

  task automatic run(input bit tmo, input bit badrd);
    @(negedge PCLK);
    mode_tmo = tmo; mode_bad = badrd;
    plan(tmo, badrd);
    go = 1'b1;
    @(negedge PCLK);
    go = 1'b0;
    for (int i = 0; i < 5000 && q.size() != 0; i++) begin
      @(negedge PCLK);
      if (go) go = 1'b0;
      else if (busy && $urandom_range(0, 40) == 0) go = 1'b1;  // must be ignored
    end
    go = 1'b0;
    if (q.size() != 0) begin bad("run_hang"); q.delete(); end
  endtask

  initial begin
    tbl[0] = {2'b00, 8'hFF, 8'h01};
    tbl[1] = {2'b00, 8'h12, 8'h80};
    tbl[2] = {2'b01, 8'h00, 8'h0A};
    tbl[3] = {2'b00, 8'hFF, 8'h00};
    tbl[4] = {2'b00, 8'h2C, 8'hFF};
    tbl[5] = {2'b01, 8'h00, 8'h00};
    tbl[6] = {2'b00, 8'h3C, 8'h32};
    tbl[7] = {2'b10, 8'h00, 8'h00};
    PRESET = 1'b1; go = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_rst("reset");
    PRESET = 1'b0;

    run(0, 0);
    run(0, 0);   // restart after DONE
    run(1, 0);   // timeout on the first write
    run(0, 0);   // restart after FAIL
`ifdef SCCB_INIT_VERIFY_EN
    run(0, 1);   // readback mismatch
    run(0, 0);
`endif

    // Reset while a write request is outstanding.
    @(negedge PCLK);
    mode_tmo = 0; mode_bad = 0;
    plan(0, 0);
    go = 1'b1;
    @(negedge PCLK);
    go = 1'b0;
    for (int i = 0; i < 50 && !sccb_start; i++) @(negedge PCLK);
    if (!sccb_start) bad("midop_wait");
    PRESET = 1'b1;
    #1;
    chk_rst("midop");
    q.delete();
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;

    for (int k = 0; k < 3; k++) run(0, 0);

    repeat (5) @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
